// File: rtl/regs_access_ctl.sv
// rtl/regs_access_ctl.sv - operand fetch and writeback controller with RAW/WAW scoreboard
module regs_access_ctl #(
  parameter int addrsize = 5,
  parameter int regsnum  = 32
) (
  input  logic                clk,
  input  logic                rst,
  // op issue
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [addrsize-1:0] op_src0,
  input  logic [addrsize-1:0] op_src1,
  input  logic [1:0]          op_src_en,
  input  logic [addrsize-1:0] op_dst,
  input  logic                op_dst_en,
  // operands out
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_a,
  output logic [31:0]         out_b,
  output logic [addrsize-1:0] out_dst,
  output logic                out_dst_en,
  // writeback channels
  input  logic                wb0_valid,
  input  logic [addrsize-1:0] wb0_addr,
  input  logic [31:0]         wb0_data,
  input  logic                wb1_valid,
  input  logic [addrsize-1:0] wb1_addr,
  input  logic [31:0]         wb1_data,
  // register file ports
  output logic [addrsize-1:0] rf_ra0,
  output logic [addrsize-1:0] rf_ra1,
  output logic [1:0]          rf_read,
  input  logic [31:0]         rf_rd0,
  input  logic [31:0]         rf_rd1,
  output logic [addrsize-1:0] rf_wa0,
  output logic [addrsize-1:0] rf_wa1,
  output logic [31:0]         rf_wd0,
  output logic [31:0]         rf_wd1,
  output logic [1:0]          rf_write,
  // debug
  output logic [regsnum-1:0]  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FETCH = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t                state;
  logic                  live;
  logic [regsnum-1:0]    commit;
  logic [regsnum-1:0]    busy_eff;
  logic [regsnum-1:0]    set_vec;
  logic                  hazard;
  logic                  accept;
  logic [1:0]            src_en_q;
  logic [addrsize-1:0]   dst_q;
  logic                  dst_en_q;
  logic                  fwd0;
  logic                  fwd1;
  logic [31:0]           fwd_val0;
  logic [31:0]           fwd_val1;

  // registers being written to the register file this cycle (they commit at the next edge)
  always_comb begin
    commit = '0;
    if (rf_write[0]) commit[rf_wa0] = 1'b1;
    if (rf_write[1]) commit[rf_wa1] = 1'b1;
  end

  // hazard check treats a committing register as already free, so a stalled op goes in its commit cycle
  always_comb begin
    busy_eff = busy & ~commit;
    hazard   = (op_src_en[0] && busy_eff[op_src0]) ||
               (op_src_en[1] && busy_eff[op_src1]) ||
               (op_dst_en    && busy_eff[op_dst]);
    op_ready = live && ((state == IDLE) || (state == VALID && out_ready)) && !hazard;
    accept   = op_valid && op_ready;
    set_vec  = '0;
    if (accept && op_dst_en) set_vec[op_dst] = 1'b1;
  end

  // op_ready is held low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  // writeback channels are registered straight onto the register-file write ports
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write <= 2'b00;
      rf_wa0   <= '0;
      rf_wa1   <= '0;
      rf_wd0   <= '0;
      rf_wd1   <= '0;
    end else begin
      rf_write <= {wb1_valid, wb0_valid};
      rf_wa0   <= wb0_addr;
      rf_wa1   <= wb1_addr;
      rf_wd0   <= wb0_data;
      rf_wd1   <= wb1_data;
    end
  end

  // scoreboard: commits clear, accepted destinations set; a set on the same edge wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~commit) | set_vec;
  end

  // issue/fetch/valid sequencing with registered register-file reads and operand capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rf_ra0     <= '0;
      rf_ra1     <= '0;
      rf_read    <= 2'b00;
      src_en_q   <= 2'b00;
      dst_q      <= '0;
      dst_en_q   <= 1'b0;
      fwd0       <= 1'b0;
      fwd1       <= 1'b0;
      fwd_val0   <= '0;
      fwd_val1   <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_dst    <= '0;
      out_dst_en <= 1'b0;
    end else begin
      if (accept) begin
        rf_ra0   <= op_src0;
        rf_ra1   <= op_src1;
        rf_read  <= op_src_en;
        src_en_q <= op_src_en;
        dst_q    <= op_dst;
        dst_en_q <= op_dst_en;
      end

      case (state)
        IDLE: begin
          if (accept) state <= ISSUE;
        end

        ISSUE: begin
          rf_read <= 2'b00;
          // a write committing on the same edge as the read is not seen by the read; keep it aside
          if (rf_write[1] && rf_wa1 == rf_ra0) begin
            fwd0     <= 1'b1;
            fwd_val0 <= rf_wd1;
          end else if (rf_write[0] && rf_wa0 == rf_ra0) begin
            fwd0     <= 1'b1;
            fwd_val0 <= rf_wd0;
          end else begin
            fwd0 <= 1'b0;
          end
          if (rf_write[1] && rf_wa1 == rf_ra1) begin
            fwd1     <= 1'b1;
            fwd_val1 <= rf_wd1;
          end else if (rf_write[0] && rf_wa0 == rf_ra1) begin
            fwd1     <= 1'b1;
            fwd_val1 <= rf_wd0;
          end else begin
            fwd1 <= 1'b0;
          end
          state <= FETCH;
        end

        FETCH: begin
          out_a      <= !src_en_q[0] ? 32'd0 : (fwd0 ? fwd_val0 : rf_rd0);
          out_b      <= !src_en_q[1] ? 32'd0 : (fwd1 ? fwd_val1 : rf_rd1);
          out_dst    <= dst_q;
          out_dst_en <= dst_en_q;
          out_valid  <= 1'b1;
          state      <= VALID;
        end

        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? ISSUE : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_access_ctl.sv
// tb/tb_regs_access_ctl.sv - scoreboard bench for regs_access_ctl with a behavioural register file
module tb_regs_access_ctl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  op_src0;
  logic [4:0]  op_src1;
  logic [1:0]  op_src_en;
  logic [4:0]  op_dst;
  logic        op_dst_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_dst;
  logic        out_dst_en;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic [4:0]  rf_ra0;
  logic [4:0]  rf_ra1;
  logic [1:0]  rf_read;
  logic [31:0] rf_rd0;
  logic [31:0] rf_rd1;
  logic [4:0]  rf_wa0;
  logic [4:0]  rf_wa1;
  logic [31:0] rf_wd0;
  logic [31:0] rf_wd1;
  logic [1:0]  rf_write;
  logic [31:0] busy;

  regs_access_ctl #(.addrsize(5), .regsnum(32)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_src0(op_src0), .op_src1(op_src1), .op_src_en(op_src_en),
    .op_dst(op_dst), .op_dst_en(op_dst_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_dst(out_dst), .out_dst_en(out_dst_en),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_read(rf_read),
    .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
    .rf_wa0(rf_wa0), .rf_wa1(rf_wa1), .rf_wd0(rf_wd0), .rf_wd1(rf_wd1),
    .rf_write(rf_write), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        dst_en;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks;
  int          failures;
  logic [31:0] rf_mem [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: registered reads see the value before same-edge writes, port 1 write lands last
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
      rf_rd0 <= 32'd0;
      rf_rd1 <= 32'd0;
    end else begin
      if (rf_read[0]) rf_rd0 <= rf_mem[rf_ra0];
      if (rf_read[1]) rf_rd1 <= rf_mem[rf_ra1];
      if (rf_write[0]) rf_mem[rf_wa0] <= rf_wd0;
      if (rf_write[1]) rf_mem[rf_wa1] <= rf_wd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // output side of the scoreboard: sampled 2 time units before the handshake edge
  always @(negedge clk) begin
    #3;
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_dst", 32'(out_dst), 32'(e.dst));
        chk("out_dst_en", 32'(out_dst_en), 32'(e.dst_en));
      end
    end
  end

  task automatic issue(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] en,
                       input logic [4:0] d, input logic de,
                       input logic [31:0] ea, input logic [31:0] eb);
    int n;
    op_src0 = s0; op_src1 = s1; op_src_en = en; op_dst = d; op_dst_en = de;
    op_valid = 1'b1;
    #1;
    n = 0;
    while (!op_ready && n < 30) begin
      @(negedge clk); #1; n++;
    end
    chk("issue_ready", 32'(op_ready), 32'd1);
    q.push_back('{a: ea, b: eb, dst: d, dst_en: de});
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    #1;
    while (!out_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic wb(input logic port, input logic [4:0] a, input logic [31:0] d);
    if (port) begin wb1_valid = 1'b1; wb1_addr = a; wb1_data = d; end
    else      begin wb0_valid = 1'b1; wb0_addr = a; wb0_data = d; end
    @(negedge clk);
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; op_valid = 1'b0; out_ready = 1'b1;
    op_src0 = '0; op_src1 = '0; op_src_en = '0; op_dst = '0; op_dst_en = 1'b0;
    wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_rf_read", 32'(rf_read), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("ready_after_rst", 32'(op_ready), 32'd1);
    @(negedge clk);

    // basic fetch with latency check
    wb(1'b0, 5'd3, 32'h11);
    wb(1'b0, 5'd4, 32'h22);
    issue(5'd3, 5'd4, 2'b11, 5'd0, 1'b0, 32'h11, 32'h22);
    #1 chk("lat_t0", 32'(out_valid), 32'd0);
    @(negedge clk); #1 chk("lat_t1", 32'(out_valid), 32'd0);
    @(negedge clk); #1 chk("lat_t2", 32'(out_valid), 32'd1);
    @(negedge clk);

    // RAW stall released in the commit cycle
    issue(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 32'd0, 32'd0);
    wait_valid();
    @(negedge clk);
    #1 chk("busy5_set", 32'(busy[5]), 32'd1);
    op_src0 = 5'd5; op_src1 = 5'd0; op_src_en = 2'b01; op_dst = 5'd0; op_dst_en = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1 chk("raw_stall", 32'(op_ready), 32'd0);
    end
    @(negedge clk);
    wb1_valid = 1'b1; wb1_addr = 5'd5; wb1_data = 32'hABCD;
    @(negedge clk);
    wb1_valid = 1'b0;
    #1;
    chk("raw_rf_write", 32'(rf_write), 32'd2);
    chk("raw_ready_commit", 32'(op_ready), 32'd1);
    q.push_back('{a: 32'hABCD, b: 32'd0, dst: 5'd0, dst_en: 1'b0});
    @(negedge clk);
    op_valid = 1'b0;
    #1 chk("busy5_clear", 32'(busy[5]), 32'd0);
    wait_valid();
    @(negedge clk);

    // forwarding of a write committing during ISSUE
    wb(1'b0, 5'd9, 32'h33);
    wb0_valid = 1'b1; wb0_addr = 5'd9; wb0_data = 32'h55;
    issue(5'd0, 5'd9, 2'b10, 5'd0, 1'b0, 32'd0, 32'h55);
    wb0_valid = 1'b0;
    wait_valid();
    @(negedge clk);

    // dual writeback collision on a busy register
    issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 32'd0, 32'd0);
    wait_valid();
    @(negedge clk);
    #1 chk("busy7_set", 32'(busy[7]), 32'd1);
    @(negedge clk);
    wb0_valid = 1'b1; wb0_addr = 5'd7; wb0_data = 32'h1;
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h2;
    @(negedge clk);
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    #1 chk("dual_rf_write", 32'(rf_write), 32'd3);
    @(negedge clk);
    #1 chk("busy7_clear", 32'(busy[7]), 32'd0);
    issue(5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 32'h2, 32'h2);
    wait_valid();
    @(negedge clk);

    // backpressure with a pending legal op taken in the release cycle
    out_ready = 1'b0;
    issue(5'd3, 5'd4, 2'b11, 5'd10, 1'b1, 32'h11, 32'h22);
    wait_valid();
    op_src0 = 5'd3; op_src1 = 5'd0; op_src_en = 2'b01; op_dst = 5'd0; op_dst_en = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_a", out_a, 32'h11);
      chk("bp_b", out_b, 32'h22);
      chk("bp_dst", 32'(out_dst), 32'd10);
      chk("bp_ready", 32'(op_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(op_ready), 32'd1);
    q.push_back('{a: 32'h11, b: 32'd0, dst: 5'd0, dst_en: 1'b0});
    @(negedge clk);
    op_valid = 1'b0;
    #1 chk("b2b_issue", 32'(out_valid), 32'd0);
    @(negedge clk); #1 chk("b2b_fetch", 32'(out_valid), 32'd0);
    @(negedge clk); #1 chk("b2b_valid", 32'(out_valid), 32'd1);
    @(negedge clk);

    // reset asserted mid-VALID with busy[5] set and a writeback in flight
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 32'd0, 32'd0);
    wait_valid();
    chk("mid_busy5", 32'(busy[5]), 32'd1);
    @(negedge clk);
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h77;
    @(negedge clk);
    wb0_valid = 1'b0;
    #1 chk("mid_rf_write", 32'(rf_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_rf_write", 32'(rf_write), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_ready", 32'(op_ready), 32'd1);
    @(negedge clk);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
